// File: rtl/branch_ctrl.sv
// Branch/jump sequencer for the multicycle CPU.
// Drives PC, ALU-operand and link controls from decode to retire.
module branch_ctrl #(
  parameter logic [5:0] OP_J   = 6'h02,
  parameter logic [5:0] OP_JAL = 6'h03,
  parameter logic [5:0] OP_BEQ = 6'h04,
  parameter logic [5:0] OP_BNE = 6'h05,
  parameter logic [5:0] OP_BLE = 6'h06,
  parameter logic [5:0] OP_BGT = 6'h07,
  parameter logic [5:0] FN_JR  = 6'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       EQorNE,
  output logic       GTorLT,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg
);

  typedef enum logic [2:0] {
    IDLE, BR, JMP, LINK, JR, DONE, ERR
  } state_t;

  state_t     state, next;
  logic [5:0] op_q;
  logic       is_br, is_j, is_jal, is_jr;

  assign is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                  (opcode == OP_BLE) || (opcode == OP_BGT);
  assign is_j   = (opcode == OP_J);
  assign is_jal = (opcode == OP_JAL);
  assign is_jr  = (opcode == 6'h00) && (funct == FN_JR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start)
        op_q <= opcode;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_br:   next = BR;
            is_j:    next = JMP;
            is_jal:  next = LINK;
            is_jr:   next = JR;
            default: next = ERR;
          endcase
        end
      end
      BR:      next = DONE;
      JMP:     next = DONE;
      LINK:    next = JMP;
      JR:      next = DONE;
      DONE:    next = IDLE;
      ERR:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Moore outputs: a function of state and the latched opcode only
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    EQorNE      = 1'b0;
    GTorLT      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemToReg    = 2'b00;
    unique case (state)
      BR: begin
        busy        = 1'b1;
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
        EQorNE      = (op_q == OP_BNE) || (op_q == OP_BGT);
        GTorLT      = (op_q != OP_BGT);
      end
      JMP: begin
        busy     = 1'b1;
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      LINK: begin
        busy     = 1'b1;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemToReg = 2'b11;
      end
      JR: begin
        busy     = 1'b1;
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b010;
        PCWrite  = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; expected control words are queued
// when stimulus is driven and checked one cycle later.
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [5:0] opcode, funct;
  logic       busy, done, err, PCWrite, PCWriteCond, EQorNE, GTorLT;
  logic [1:0] PCSource, ALUSrcB, RegDst, MemToReg;
  logic       ALUSrcA, RegWrite;
  logic [2:0] ALUOp;

  int checks = 0;
  int errors = 0;

  logic [19:0] sb_q[$];
  logic [19:0] obs;

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .opcode(opcode), .funct(funct),
    .busy(busy), .done(done), .err(err),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .EQorNE(EQorNE), .GTorLT(GTorLT), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg)
  );

  // busy done err PCW PCWC EQ GT PCS[2] A B[2] OP[3] RW RD[2] M2R[2]
  assign obs = {busy, done, err, PCWrite, PCWriteCond, EQorNE, GTorLT,
                PCSource, ALUSrcA, ALUSrcB, ALUOp,
                RegWrite, RegDst, MemToReg};

  localparam logic [19:0] E_IDLE = 20'h0;
  localparam logic [19:0] E_JMP  =
    {3'b100, 4'b1000, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};
  localparam logic [19:0] E_LINK =
    {3'b100, 4'b0000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, 2'b10, 2'b11};
  localparam logic [19:0] E_JR   =
    {3'b100, 4'b1000, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 2'b00};
  localparam logic [19:0] E_DONE =
    {3'b110, 4'b0000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};
  localparam logic [19:0] E_ERR  =
    {3'b001, 4'b0000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};

  function automatic logic [19:0] e_br(input logic eq, input logic gt);
    return {3'b100, 1'b0, 1'b1, eq, gt, 2'b01, 1'b1, 2'b00, 3'b001,
            1'b0, 2'b00, 2'b00};
  endfunction

  task automatic step(input logic r, input logic s, input logic [5:0] op,
                      input logic [5:0] fn, input logic [19:0] e,
                      input string tag);
    logic [19:0] x;
    reset  = r;
    start  = s;
    opcode = op;
    funct  = fn;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s obs=%05h exp=%05h", tag, obs, x);
    end
  endtask

  task automatic idle(input logic [19:0] e, input string tag);
    step(1'b0, 1'b0, 6'h00, 6'h00, e, tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; funct = '0;
    step(1'b1, 1'b0, 6'h00, 6'h00, E_IDLE, "rst0");
    step(1'b1, 1'b1, 6'h04, 6'h00, E_IDLE, "rst1_start");

    step(1'b0, 1'b1, 6'h04, 6'h00, e_br(1'b0, 1'b1), "beq_br");
    idle(E_DONE, "beq_done");
    idle(E_IDLE, "beq_idle");

    step(1'b0, 1'b1, 6'h05, 6'h00, e_br(1'b1, 1'b1), "bne_br");
    idle(E_DONE, "bne_done");
    idle(E_IDLE, "bne_idle");
    step(1'b0, 1'b1, 6'h06, 6'h00, e_br(1'b0, 1'b1), "ble_br");
    idle(E_DONE, "ble_done");
    idle(E_IDLE, "ble_idle");
    step(1'b0, 1'b1, 6'h07, 6'h00, e_br(1'b1, 1'b0), "bgt_br");
    idle(E_DONE, "bgt_done");
    idle(E_IDLE, "bgt_idle");

    step(1'b0, 1'b1, 6'h03, 6'h00, E_LINK, "jal_link");
    idle(E_JMP, "jal_jmp");
    idle(E_DONE, "jal_done");
    idle(E_IDLE, "jal_idle");

    step(1'b0, 1'b1, 6'h00, 6'h08, E_JR, "jr_jr");
    idle(E_DONE, "jr_done");
    idle(E_IDLE, "jr_idle");

    step(1'b0, 1'b1, 6'h00, 6'h20, E_ERR, "bad_fn_err");
    idle(E_IDLE, "bad_fn_idle");
    step(1'b0, 1'b1, 6'h3f, 6'h08, E_ERR, "bad_op_err");
    idle(E_IDLE, "bad_op_idle");

    // starts during JMP and DONE must be ignored
    step(1'b0, 1'b1, 6'h02, 6'h00, E_JMP, "j_jmp");
    step(1'b0, 1'b1, 6'h04, 6'h00, E_DONE, "j_start_in_jmp");
    step(1'b0, 1'b1, 6'h04, 6'h00, E_IDLE, "j_start_in_done");
    step(1'b0, 1'b1, 6'h07, 6'h00, e_br(1'b1, 1'b0), "j_next_br");
    step(1'b0, 1'b1, 6'h02, 6'h00, E_DONE, "j_next_done");
    idle(E_IDLE, "j_next_idle");

    // reset abandons in-flight instructions
    step(1'b0, 1'b1, 6'h03, 6'h00, E_LINK, "rl_link");
    step(1'b1, 1'b0, 6'h00, 6'h00, E_IDLE, "rl_reset");
    idle(E_IDLE, "rl_idle");
    idle(E_IDLE, "rl_idle2");
    step(1'b0, 1'b1, 6'h05, 6'h00, e_br(1'b1, 1'b1), "rb_br");
    step(1'b1, 1'b0, 6'h00, 6'h00, E_IDLE, "rb_reset");
    idle(E_IDLE, "rb_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
